// File: rtl/ara_pkg.sv
// Shared Ara types used by the issue stage: instruction ids and the
// request record that is broadcast to the processing elements.
package ara_pkg;

  localparam int unsigned NrVInsn = 8;

  typedef logic [$clog2(NrVInsn)-1:0] vid_t;

  typedef struct packed {
    vid_t               id;
    logic [7:0]         op;
    logic [4:0]         vd;
    logic [4:0]         vs1;
    logic [4:0]         vs2;
    logic               vm;
    logic [15:0]        vl;
    logic [NrVInsn-1:0] vinsn_running;
    logic [NrVInsn-1:0] hazard_vs1;
    logic [NrVInsn-1:0] hazard_vs2;
    logic [NrVInsn-1:0] hazard_vm;
    logic [NrVInsn-1:0] hazard_vd;
  } pe_req_t;

endpackage

// File: rtl/ara_pe_req_broadcast.sv
// Issue stage that holds one request and lets every targeted PE accept it
// independently; reports completion and how long the request has stalled.
module ara_pe_req_broadcast
  import ara_pkg::*;
#(
  parameter int unsigned NrLanes       = 1,
  parameter int unsigned NrPEs         = NrLanes + 4,
  parameter int unsigned StallCntWidth = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  pe_req_t                  req_i,
  input  logic [NrPEs-1:0]         req_target_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [NrVInsn-1:0]       vinsn_running_i,
  output pe_req_t                  pe_req_o,
  output logic [NrPEs-1:0]         pe_req_valid_o,
  input  logic [NrPEs-1:0]         pe_req_ready_i,
  output logic                     issue_done_o,
  output vid_t                     issue_id_o,
  output logic                     busy_o,
  output logic [StallCntWidth-1:0] stall_cnt_o
);

  // Handshake: a transfer on any channel happens in a cycle where both valid
  // and ready are high; valid never depends on the ready it is paired with.
  logic                     valid_q;
  pe_req_t                  req_q;
  logic [NrPEs-1:0]         target_q;
  logic [NrPEs-1:0]         acc_q;
  logic [StallCntWidth-1:0] stall_q;

  logic [NrPEs-1:0] pending;
  logic             complete;
  logic             load;

  always_comb begin
    pending        = target_q & ~acc_q;
    pe_req_valid_o = {NrPEs{valid_q}} & pending;
    complete       = valid_q & ((pending & ~pe_req_ready_i) == '0);
    req_ready_o    = !valid_q | complete;
    load           = req_valid_i & req_ready_o;
  end

  assign pe_req_o     = req_q;
  assign issue_done_o = complete;
  assign issue_id_o   = req_q.id;
  assign busy_o       = valid_q;
  assign stall_cnt_o  = stall_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q  <= 1'b0;
      req_q    <= '0;
      target_q <= '0;
      acc_q    <= '0;
      stall_q  <= '0;
    end else if (load) begin
      valid_q  <= 1'b1;
      req_q    <= req_i;
      target_q <= req_target_i;
      acc_q    <= '0;
      stall_q  <= '0;
    end else if (valid_q) begin
      if (complete) valid_q <= 1'b0;
      acc_q <= acc_q | (pe_req_valid_o & pe_req_ready_i);
      // Retired instructions no longer constrain the waiting request.
      req_q.vinsn_running <= vinsn_running_i;
      req_q.hazard_vs1    <= req_q.hazard_vs1 & vinsn_running_i;
      req_q.hazard_vs2    <= req_q.hazard_vs2 & vinsn_running_i;
      req_q.hazard_vm     <= req_q.hazard_vm  & vinsn_running_i;
      req_q.hazard_vd     <= req_q.hazard_vd  & vinsn_running_i;
      if (!complete && (stall_q != '1)) stall_q <= stall_q + 1'b1;
    end
  end

endmodule

// File: doc/ara_pe_req_broadcast.md
# ara_pe_req_broadcast

- Decoupled issue stage between the sequencer and Ara's NrPEs processing elements (lanes, load, store, slide, mask units).
- Holds one `pe_req_t` and offers it to the PEs named in a per-request target mask.
- Tracks which PEs have accepted, so each PE handshakes independently rather than all PEs in lockstep.
- While the request waits, refreshes its `vinsn_running` and hazard fields. Reports completion and stall length back to the sequencer.

## Interface

Reset is synchronous and active-high; the block has a single clock.

Parameters:
- `NrLanes`, default 1: number of lanes.
- `NrPEs`, default NrLanes+4: number of PEs. Derived; do not override.
- `StallCntWidth`, default 16: width of the stall counter.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  synchronous, active-high reset.
- `req_i`  in  pe_req_t  request from the sequencer.
- `req_target_i`  in  NrPEs  PEs that must accept `req_i`. Bit p set means PE p.
- `req_valid_i`  in  1  request valid.
- `req_ready_o`  out  1  request accepted. Combinational in `pe_req_ready_i`.
- `vinsn_running_i`  in  NrVInsn  current running-instruction vector (the sequencer's next-state value).
- `pe_req_o`  out  pe_req_t  held request, broadcast to all PEs.
- `pe_req_valid_o`  out  NrPEs  per-PE valid.
- `pe_req_ready_i`  in  NrPEs  per-PE ready.
- `issue_done_o`  out  1  one-cycle pulse: the held request was accepted by all its targets.
- `issue_id_o`  out  vid_t  `pe_req_o.id` of the completing request. Meaningful only while `issue_done_o` is high.
- `busy_o`  out  1  a request is held.
- `stall_cnt_o`  out  StallCntWidth  cycles the current request has been held without completing.

## Operation

State:
- `valid_q`: a request is held.
- `req_q`: the held request.
- `target_q`: its target mask.
- `acc_q`: NrPEs mask of PEs that have already accepted.
- `stall_q`: the stall counter.

Handshake and completion:
- `pending = target_q & ~acc_q`.
- `pe_req_valid_o[p] = valid_q & pending[p]`.
- PE p accepts in a cycle when `pe_req_valid_o[p] & pe_req_ready_i[p]`. On the next edge, `acc_q[p]` is set.
- `complete = valid_q & ((pending & ~pe_req_ready_i) == 0)`.
- `issue_done_o = complete`.
- On completion, `valid_q` clears unless a new request loads in the same cycle.
- `req_ready_o = !valid_q | complete`.
- On load (`req_valid_i & req_ready_o`):
  - `req_q <= req_i`, `target_q <= req_target_i`, `acc_q <= 0`, `stall_q <= 0`, `valid_q <= 1`.

Refresh of the held request, every cycle while `valid_q` and the request is not being replaced:
- `vinsn_running <= vinsn_running_i`.
- `hazard_vs1`, `hazard_vs2`, `hazard_vm` and `hazard_vd` are each ANDed with `vinsn_running_i`.
- All other fields stay frozen.
- A request loaded this cycle is stored unmodified; refresh starts on the following cycle.

Stall counter:
- Increments each held cycle without `complete`.
- Saturates at 2^StallCntWidth−1.
- Cleared on load.

Boundary cases:
- **Zero target mask:** the request loads normally. With `pending == 0`, `complete` is high in its first held cycle. All `pe_req_valid_o` stay 0 and `issue_done_o` pulses.
- **Target bit set while that PE is ready in the first held cycle:** the PE accepts that cycle; no extra cycle.
- **`req_valid_i` held while busy and not completing:** not accepted; `req_i` must stay stable (standard valid/ready).
- **Reset mid-request:** `valid_q`, `acc_q` and `stall_q` clear on the next edge. PEs that already accepted are not recalled; flushing them is the sequencer's job.

## Timing

- Reset values: `req_ready_o`=1 (idle), `pe_req_o`=0, `pe_req_valid_o`=0, `issue_done_o`=0, `issue_id_o`=0, `busy_o`=0, `stall_cnt_o`=0.
- A load at edge N gives `pe_req_valid_o` high in cycle N+1. If all targets are ready in N+1, `issue_done_o` is also high in N+1.
- Back-to-back throughput is one request per cycle; a new load may happen in the completing cycle.
- Minimum latency from `req_valid_i` to `issue_done_o` is 1 cycle.
- Combinational paths: `pe_req_ready_i` → `req_ready_o` and `pe_req_ready_i` → `issue_done_o`. There is no path from `req_valid_i` to any output.

## Structure

- Uses `ara_pkg` `pe_req_t`, `vid_t` and `NrVInsn`. No new typedefs.
- The sequencer computes the target mask from `NrLanes` and the `OffsetLoad/Store/Slide/Mask` constants.
- Single flat module; no sub-module warranted.

## Test plan

Bench configuration: NrLanes=4, NrPEs=8.

1. **All targets ready:** target 8'h0F, all ready → `issue_done_o` in the cycle after load; `stall_cnt_o`=0; `issue_id_o` equals the loaded id.
2. **Staggered acceptance:** target 8'h0F; PE0 ready at cycle 1, PE1–2 at cycle 3, PE3 at cycle 5 →
   - each PE's valid drops the cycle after it accepts;
   - done at cycle 5;
   - `stall_cnt_o`=4 in cycle 5.
3. **Zero target:** target 0 → no `pe_req_valid_o` bits; `issue_done_o` pulses in the first held cycle.
4. **Hazard refresh:** held request with `hazard_vs1`=8'b0000_0110; `vinsn_running_i` drops bit 2 → the next cycle `pe_req_o.hazard_vs1`=8'b0000_0010.
5. **Back-to-back:** three requests with full ready → three consecutive `issue_done_o` pulses; `req_ready_o` stays high.
6. **Reset mid-request:** `rst_i` pulsed while 2 of 4 targets have accepted → all outputs return to reset values on the next edge.
